// File: rtl/fir_folded_mc.sv
// Multi-channel folded FIR with one shared MAC and coefficient bank; result valid N edges after accept.
// Backpressure: OUT holds the result until out_ready, and in_ready stays low while MAC or OUT is active.
module fir_folded_mc #(
    parameter int N    = 16,
    parameter int CH   = 2,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = CW - 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   coef_we,
    input  logic [$clog2(N)-1:0]                   coef_addr,
    input  logic [CW-1:0]                          coef_wdata,
    input  logic                                   flush,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] in_ch,
    input  logic [DW-1:0]                          in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
    output logic [DW-1:0]                          out_data,
    output logic                                   out_sat,
    output logic                                   busy
);
    localparam int KW  = $clog2(N);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int AW  = DW + CW + KW;
    localparam int PW  = DW + CW;
    localparam logic signed [AW:0] RND  = (AW+1)'(1) <<< (FRAC - 1);
    localparam logic signed [AW:0] MAXV = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                state, state_nx;
    logic signed [DW-1:0]  dly [CH][N];
    logic [KW-1:0]         wp [CH];
    logic signed [CW-1:0]  h [N];
    logic [CHW-1:0]        c;
    logic [KW-1:0]         rp;
    logic [KW-1:0]         k;
    logic signed [AW-1:0]  acc;

    logic                  accept;
    logic                  last;
    logic [CHW-1:0]        ch_sel;
    logic [KW-1:0]         wp_inc;
    logic signed [DW-1:0]  x_rd;
    logic signed [CW-1:0]  h_rd;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  sum;
    logic signed [AW:0]    rnd_s;
    logic signed [AW:0]    r_s;
    logic                  sat_hi;
    logic                  sat_lo;
    logic [DW-1:0]         res;

    assign in_ready = (state == S_IDLE) && !flush;
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (k == KW'(N - 1));
    assign ch_sel   = (CH > 1) ? in_ch : '0;
    assign wp_inc   = (wp[ch_sel] == KW'(N - 1)) ? '0 : wp[ch_sel] + 1'b1;

    // rp walks backwards from the newest sample, so tap k reads x[n-k]
    assign x_rd   = dly[c][rp];
    assign h_rd   = h[k];
    assign prod   = x_rd * h_rd;
    assign sum    = acc + AW'(prod);
    assign rnd_s  = {sum[AW-1], sum} + RND;
    assign r_s    = rnd_s >>> FRAC;
    assign sat_hi = (r_s > MAXV);
    assign sat_lo = (r_s < MINV);
    assign res    = sat_hi ? MAXV[DW-1:0] : (sat_lo ? MINV[DW-1:0] : r_s[DW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept)    state_nx = S_MAC;
            S_MAC:   if (last)      state_nx = S_OUT;
            S_OUT:   if (out_ready) state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                wp[i] <= '0;
                for (int j = 0; j < N; j++) dly[i][j] <= '0;
            end
            for (int j = 0; j < N; j++) h[j] <= '0;
            c         <= '0;
            rp        <= '0;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (state == S_IDLE && coef_we) h[coef_addr] <= coef_wdata;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        for (int i = 0; i < CH; i++) begin
                            wp[i] <= '0;
                            for (int j = 0; j < N; j++) dly[i][j] <= '0;
                        end
                    end else if (accept) begin
                        dly[ch_sel][wp[ch_sel]] <= in_data;
                        wp[ch_sel] <= wp_inc;
                        c          <= ch_sel;
                        rp         <= wp[ch_sel];
                        acc        <= '0;
                        k          <= '0;
                    end
                end
                S_MAC: begin
                    acc <= sum;
                    k   <= k + 1'b1;
                    rp  <= (rp == '0) ? KW'(N - 1) : rp - 1'b1;
                    if (last) begin
                        out_data  <= res;
                        out_ch    <= c;
                        out_sat   <= sat_hi || sat_lo;
                        out_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_folded_mc.sv
// Directed and randomized bench for fir_folded_mc against a linear-history FIR model.
module tb_fir_folded_mc;
    localparam int N    = 16;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int FRAC = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_ch = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_ch;
    logic [15:0] out_data;
    logic        out_sat;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int hm [N];
    int hist [2][$];

    fir_folded_mc #(.N(N), .CH(2), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // y[n] = sat(round(sum_k x[n-k]*h[k])), missing history treated as zero
    task automatic model_exp(int ch, output longint d, output longint s);
        longint a;
        longint r;
        a = 0;
        for (int i = 0; i < N; i++)
            if (i < hist[ch].size()) a += longint'(hist[ch][i]) * longint'(hm[i]);
        r = (a + (longint'(1) << (FRAC - 1))) >>> FRAC;
        s = 0;
        if (r > 32767) begin r = 32767; s = 1; end
        else if (r < -32768) begin r = -32768; s = 1; end
        d = r;
    endtask

    task automatic wr_coef(int idx, int v);
        coef_we = 1'b1; coef_addr = idx[3:0]; coef_wdata = v[15:0];
        @(posedge clk); #1;
        coef_we = 1'b0;
        hm[idx] = v;
    endtask

    task automatic set_all(int v);
        for (int i = 0; i < N; i++) wr_coef(i, v);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        hist[0].delete();
        hist[1].delete();
    endtask

    task automatic send(int ch, int x, int hold = 0, bit we_mac = 0);
        int cnt;
        longint ed;
        longint es;
        cnt = 0;
        while (!in_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
        chk("in_ready_before_accept", in_ready, 1);
        out_ready = (hold == 0);
        in_valid = 1'b1; in_ch = ch[0]; in_data = x[15:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        hist[ch].push_front(x);
        if (hist[ch].size() > N) void'(hist[ch].pop_back());
        model_exp(ch, ed, es);
        if (we_mac) begin coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'h3039; end
        cnt = 0;
        while (!out_valid && cnt < 50) begin @(posedge clk); #1; coef_we = 1'b0; cnt++; end
        chk("latency", cnt, N);
        chk("out_data", $signed(out_data), ed);
        chk("out_ch", out_ch, ch);
        chk("out_sat", out_sat, es);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk("bp_out_valid", out_valid, 1);
                chk("bp_out_data", $signed(out_data), ed);
                chk("bp_out_ch", out_ch, ch);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_busy", busy, 1);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("out_valid_after_hs", out_valid, 0);
        chk("out_data_kept", $signed(out_data), ed);
        if (hold > 0) chk("in_ready_after_hs", in_ready, 1);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < N; i++) hm[i] = 0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // impulse through tap 3
        wr_coef(3, 16384);
        send(0, 1000);
        for (int i = 0; i < 19; i++) send(0, 0);

        // channel isolation
        do_flush();
        set_all(0);
        wr_coef(1, 32767);
        send(0, 1000);
        send(1, -2000);
        send(0, 0);
        send(1, 0);

        // rounding at the half-LSB boundary
        do_flush();
        set_all(0);
        wr_coef(0, 1);
        send(0, 16384);
        send(0, 16383);
        send(0, -16384);

        // saturation both ways
        do_flush();
        set_all(32767);
        for (int i = 0; i < N; i++) send(0, 32767);
        do_flush();
        for (int i = 0; i < N; i++) send(1, -32768);

        // back-pressure
        send(0, 1234, 5);

        // wrap-around with a two-tap averager
        do_flush();
        set_all(0);
        wr_coef(0, 16384);
        wr_coef(15, 16384);
        for (int i = 0; i < 40; i++) send(1, i * 301 - 5000);

        // flush then impulse: no residue
        do_flush();
        send(1, 1000);
        for (int i = 0; i < 3; i++) send(1, 0);

        // coefficient write during MAC is ignored
        send(0, 2000, 0, 1'b1);
        send(0, 700);

        // randomized coefficients, samples and channels
        do_flush();
        for (int i = 0; i < N; i++) wr_coef(i, int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 36; i++)
            send(int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768);

        // reset in the middle of MAC
        in_valid = 1'b1; in_ch = 1'b0; in_data = 16'd5000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        hist[0].delete();
        hist[1].delete();
        for (int i = 0; i < N; i++) hm[i] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("midrst_no_output", seen, 0);
        chk("midrst_out_data", out_data, 0);

        // fresh block response after reprogramming
        wr_coef(3, 16384);
        send(0, 1000);
        for (int i = 0; i < 4; i++) send(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_folded_mc.md
# fir_folded_mc

Multi-channel, time-multiplexed FIR filter for the filter suite. It uses one multiplier-accumulator, which is folded over N taps, and one programmable coefficient bank shared by CH independent channels. It generalises the fixed-width, always-streaming filters to parametrised data and coefficient widths, channel count and tap count. It adds a valid/ready handshake on both sides, a runtime coefficient write port, a flush, and rounded, saturating output.

## Interface
- N, 16: tap count; N ≥ 2.
- CH, 2: channel count; power of two, ≥ 1.
- DW, 16: sample width (signed, input and output).
- CW, 16: coefficient width (signed).
- FRAC, CW-1: fractional bits of the coefficient (Q-format shift).
- Derived: AW = DW+CW+$clog2(N) accumulator width; CHW = max(1,$clog2(CH)); KW = $clog2(N).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  KW  tap index k.
- coef_wdata  in  CW  value for h[k].
- flush  in  1  clear all delay lines and pointers.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_ch  in  CHW  channel of the input sample.
- in_data  in  DW  input sample.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_ch  out  CHW  channel of the result.
- out_data  out  DW  filtered sample.
- out_sat  out  1  result was clipped.
- busy  out  1  state machine is in MAC or OUT.

## Operation
- Storage:
  - Coefficient bank h[0..N-1].
  - Per channel, a circular delay line buf[c][0..N-1] and a write pointer wp[c].
  - Everything resets to 0.
- State machine has three states: IDLE, MAC, OUT.
- IDLE:
  - in_ready = 1 unless flush = 1.
  - flush = 1 zeroes every buf and every wp in one edge. flush has priority over a sample accept.
  - Accept when in_valid & in_ready:
    - write buf[in_ch][wp[in_ch]] <= in_data;
    - latch channel c = in_ch and base pointer p = wp[in_ch];
    - wp[in_ch] <= (wp+1) mod N;
    - acc <= 0, k <= 0; go to MAC.
- MAC, one tap per edge:
  - acc += buf[c][(p-k) mod N] * h[k]. The product is a full DW+CW signed product, sign-extended to AW.
  - When k = N-1, the edge loads the result registers and moves to OUT:
    - out_data <= sat(round(acc + last product));
    - out_ch <= c;
    - out_sat <= clip flag;
    - out_valid <= 1.
  - A sample written in the accept edge is visible to tap 0 in the first MAC edge.
- Rounding: r = (a + 2^(FRAC-1)) >>> FRAC, arithmetic (round half up).
- Saturation: clamp r to [-2^(DW-1), 2^(DW-1)-1]; out_sat = 1 iff clamped. The accumulator cannot overflow at width AW.
- OUT:
  - out_valid, out_data, out_ch and out_sat stay stable until out_valid & out_ready.
  - On that handshake edge: out_valid <= 0, go to IDLE.
  - out_data, out_ch and out_sat keep their last value after the handshake.
- Coefficient writes:
  - Honoured only in IDLE; coef_we in MAC or OUT is ignored.
  - A write in the same edge as an accept takes effect for that sample.
  - Writes are allowed during flush.
- busy = (state != IDLE). in_ready = (state == IDLE) & ~flush.
- in_ch is ignored when CH = 1.

## Timing
- Reset values (async assert, applied immediately): state IDLE, out_valid 0, out_data 0, out_ch 0, out_sat 0, busy 0, acc 0, all buf, wp and h = 0. in_ready = 1 once rst_n is high.
- Reset mid-operation: the in-flight result is discarded and nothing is emitted. Coefficients are also cleared.
- Latency: accept edge E0 → out_valid high after edge E_N (N edges later).
- Throughput with out_ready tied high: one sample per N+2 cycles. The handshake occurs at E_{N+1}; the next accept is at E_{N+2}.
- Back-pressure: out_ready low holds OUT indefinitely, with in_ready = 0 the whole time.
- Wrap-around: wp wraps from N-1 to 0, and tap addressing is modulo N. Outputs are identical to a linear shift register.

## Test plan
- Impulse: N=16, DW=CW=16, FRAC=15, h[3]=16384, all other taps 0. ch0 input 1000 followed by 19 zeros → outputs 0,0,0,500,0…; out_sat=0; out_valid exactly 16 edges after each accept.
- Channel isolation: h[1]=32767. Interleave ch0 = {1000,0} with ch1 = {-2000,0} → ch0 outputs 0, 1000; ch1 outputs 0, -2000. No cross-channel leakage.
- Rounding/saturation:
  - h[0]=1: x=16384 → 1; x=16383 → 0; x=-16384 → 0.
  - All h=32767, feed 16 × 32767 → 16th output 32767 with out_sat=1.
  - All h=32767, feed 16 × -32768 → 16th output -32768 with out_sat=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → out_data, out_ch and out_valid stable; in_ready=0; busy=1. One handshake follows, then in_ready=1 the next cycle.
- Wrap and flush:
  - Feed 40 ramp samples with h[0]=h[15]=16384 → output n = round((x[n]+x[n-15])/2).
  - Pulse flush in IDLE, then impulse → no residue from the earlier samples.
  - Write coef_we during MAC → h unchanged.
- Reset mid-MAC: drop rst_n at MAC edge 7 → out_valid=0 immediately; no output is produced. After release, reprogram h and send an impulse → response matches a fresh block.
